serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
- Bit-serial N-bit adder: the sequential, additive counterpart of the full subtractor cell.
- Accepts two operands and a carry-in on a start pulse.
- Processes one bit per clock, LSB first, through a single full-adder cell with a registered carry.
- Presents sum and carry-out with a one-cycle done pulse.
- Used where area matters more than latency.

Parameters:
- WIDTH, 8, operand and sum width in bits (legal range 1..32).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only while idle.
- a  input  WIDTH  operand A; captured on the accepted start edge.
- b  input  WIDTH  operand B; captured on the accepted start edge.
- carry_in  input  1  initial carry; captured on the accepted start edge.
- busy  output  1  high while a serial addition is in progress.
- done  output  1  one-cycle pulse when the result becomes valid.
- sum  output  WIDTH  result; holds its value until the next completion.
- carry_out  output  1  final carry; holds its value until the next completion.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE; busy=0, done=0, sum=0, carry_out=0.
  - All internal shift registers, carry register and bit counter cleared.
- States: IDLE and SHIFT.
- IDLE, start=1 at edge E0:
  - Load a_sh<=a, b_sh<=b, c<=carry_in, cnt<=0, acc<=0.
  - Next state SHIFT; busy<=1.
- IDLE, start=0: no change; done<=0.
- SHIFT, edge E(i+1), i=0..WIDTH-1:
  - s = a_sh[0]^b_sh[0]^c; co = majority(a_sh[0], b_sh[0], c).
  - acc <= {s, acc[WIDTH-1:1]}; a_sh, b_sh shift right 1; c <= co; cnt <= cnt+1.
- Final bit (cnt==WIDTH-1), edge E(WIDTH):
  - sum <= {s, acc[WIDTH-1:1]}; carry_out <= co; done <= 1; busy <= 0; state <= IDLE.
- Latency: done is high during the cycle after edge E(WIDTH), i.e. WIDTH edges after start is accepted. It is high for exactly one cycle and cleared at E(WIDTH+1).
- Throughput: a new start is accepted at the earliest at E(WIDTH+1). Back-to-back operations are one per WIDTH+1 cycles.
- start while busy=1: ignored. Operands and carry are not re-captured; the in-flight operation is unaffected.
- Changes on a, b or carry_in after the accepted start edge do not affect the result.
- Arithmetic: {carry_out, sum} = a + b + carry_in, exact and unsigned. The counter is sized to hold WIDTH-1.
- WIDTH=1: a single SHIFT cycle; done at E1.
- Reset mid-operation: immediate return to reset values. No done pulse; the partial result is discarded.

Decomposition:
- Shared package:
  - state encoding constants ST_IDLE and ST_SHIFT.
  - counter width function clog2-based, minimum 1 bit.
- Sub-module: full_adder, a combinational bit cell (inputs a, b, carry_in; outputs s, carry_out). Instantiated once in the serial datapath. It is the additive dual of the existing full subtractor cell and is reusable by the wider arithmetic library.

Test Plan:
- WIDTH=8, a=8'h3C, b=8'h05, carry_in=0, start at E0 -> busy=1 from E0 to E8; done pulse after E8; sum=8'h41, carry_out=0.
- a=8'hFF, b=8'h01, carry_in=0 -> sum=8'h00, carry_out=1. Then a=8'hFF, b=8'hFF, carry_in=1 -> sum=8'hFF, carry_out=1; done once per operation.
- Start a=8'h10, b=8'h20. Re-assert start with a=8'hAA, b=8'h55 at E3 and change the inputs mid-run -> result 8'h30, carry_out=0. Only one done pulse; the second start is not captured.
- Reset asserted at E4 of an operation -> busy, done, sum, carry_out go to 0 asynchronously. After release, a new start (8'h01+8'h01) gives 8'h02 at the proper latency.
- Back-to-back: start held high continuously -> operations accepted at E0, E9, E18. Each done pulse is one cycle wide, and sum holds between completions.
- WIDTH=1, exhaustive over all 8 (a, b, carry_in) combinations -> {carry_out, sum} equals a+b+carry_in; done after E1 each time.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and
// bit-counter sizing.
package serial_adder_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    // Counter must hold WIDTH-1; a 1-bit operand still needs a 1-bit counter.
    function automatic int cnt_width(input int width);
        int w;
        w = $clog2(width);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/serial_adder_full_adder.sv
// Combinational one-bit full adder cell, the additive dual of the full
// subtractor cell in the arithmetic library.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic carry_in,
    output logic s,
    output logic carry_out
);

    assign s         = a ^ b ^ carry_in;
    assign carry_out = (a & b) | (a & carry_in) | (b & carry_in);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell with a registered carry
// consumes one operand bit per clock, LSB first, and pulses done on completion.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             c_q, c_d;
    logic             carry_out_q, carry_out_d;
    logic             done_q, done_d;

    logic             fa_s;
    logic             fa_co;
    logic             last_bit;
    logic [WIDTH-1:0] acc_shifted;

    full_adder u_fa (
        .a         (a_sh_q[0]),
        .b         (b_sh_q[0]),
        .carry_in  (c_q),
        .s         (fa_s),
        .carry_out (fa_co)
    );

    assign last_bit = (cnt_q == LAST_CNT);
    // New sum bit enters at the MSB so that after WIDTH shifts bit 0 lands at the LSB.
    assign acc_shifted = (acc_q >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            acc_q       <= '0;
            sum_q       <= '0;
            cnt_q       <= '0;
            c_q         <= 1'b0;
            carry_out_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_sh_q      <= a_sh_d;
            b_sh_q      <= b_sh_d;
            acc_q       <= acc_d;
            sum_q       <= sum_d;
            cnt_q       <= cnt_d;
            c_q         <= c_d;
            carry_out_q <= carry_out_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start)    state_d = ST_SHIFT;
            ST_SHIFT: if (last_bit) state_d = ST_IDLE;
            default:                state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        a_sh_d      = a_sh_q;
        b_sh_d      = b_sh_q;
        acc_d       = acc_q;
        sum_d       = sum_q;
        cnt_d       = cnt_q;
        c_d         = c_q;
        carry_out_d = carry_out_q;
        done_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_sh_d = a;
                    b_sh_d = b;
                    c_d    = carry_in;
                    cnt_d  = '0;
                    acc_d  = '0;
                end
            end
            ST_SHIFT: begin
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                acc_d  = acc_shifted;
                c_d    = fa_co;
                cnt_d  = cnt_q + CNT_W'(1);
                if (last_bit) begin
                    sum_d       = acc_shifted;
                    carry_out_d = fa_co;
                    done_d      = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        busy      = (state_q == ST_SHIFT);
        done      = done_q;
        sum       = sum_q;
        carry_out = carry_out_q;
    end

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: directed operations on an 8-bit and a
// 1-bit instance, results and latency checked by per-instance monitors.
module tb_serial_adder;

    typedef struct {
        logic [7:0] s;
        logic       co;
        int         cyc;
    } exp_t;

    logic       clk;
    logic       rst_n;

    logic       start8;
    logic [7:0] a8, b8;
    logic       cin8;
    logic       busy8, done8, co8;
    logic [7:0] sum8;

    logic       start1;
    logic [0:0] a1, b1;
    logic       cin1;
    logic       busy1, done1, co1;
    logic [0:0] sum1;

    int   tests_run;
    int   tests_failed;
    int   cyc;
    exp_t q8[$];
    exp_t q1[$];
    exp_t e8, e1;

    serial_adder #(.WIDTH(8)) u_dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start8),
        .a         (a8),
        .b         (b8),
        .carry_in  (cin8),
        .busy      (busy8),
        .done      (done8),
        .sum       (sum8),
        .carry_out (co8)
    );

    serial_adder #(.WIDTH(1)) u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start1),
        .a         (a1),
        .b         (b1),
        .carry_in  (cin1),
        .busy      (busy1),
        .done      (done1),
        .sum       (sum1),
        .carry_out (co1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run = tests_run + 1;
        if (actual !== expected) begin
            tests_failed = tests_failed + 1;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, actual, expected, $time);
        end
    endtask

    // Issues one start pulse and records the expected result and completion cycle.
    task automatic applyStimulus(input bit narrow, input logic [7:0] av, input logic [7:0] bv,
                                 input logic cv, input logic [7:0] exp_s, input logic exp_co);
        exp_t e;
        @(negedge clk);
        e.s  = exp_s;
        e.co = exp_co;
        if (narrow) begin
            start1 = 1'b1; a1 = av[0]; b1 = bv[0]; cin1 = cv;
            e.cyc = cyc + 2;
            q1.push_back(e);
        end else begin
            start8 = 1'b1; a8 = av; b8 = bv; cin8 = cv;
            e.cyc = cyc + 9;
            q8.push_back(e);
        end
        @(posedge clk);
        #1;
        start1 = 1'b0;
        start8 = 1'b0;
    endtask

    task automatic waitDone(input bit narrow, input int budget, input string name);
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            if ((narrow && done1) || (!narrow && done8)) break;
            n = n + 1;
            if (n >= budget) begin
                checkOutput({name, "_timeout"}, 32'd0, 32'd1);
                break;
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && done8) begin
            if (q8.size() == 0) begin
                checkOutput("w8_unexpected_done", 32'd1, 32'd0);
            end else begin
                e8 = q8.pop_front();
                checkOutput("w8_sum", 32'(sum8), 32'(e8.s));
                checkOutput("w8_carry_out", 32'(co8), 32'(e8.co));
                checkOutput("w8_latency", 32'(cyc), 32'(e8.cyc));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && done1) begin
            if (q1.size() == 0) begin
                checkOutput("w1_unexpected_done", 32'd1, 32'd0);
            end else begin
                e1 = q1.pop_front();
                checkOutput("w1_sum", 32'(sum1), 32'(e1.s));
                checkOutput("w1_carry_out", 32'(co1), 32'(e1.co));
                checkOutput("w1_latency", 32'(cyc), 32'(e1.cyc));
            end
        end
    end

    initial begin
        logic [1:0] exp1;
        tests_run    = 0;
        tests_failed = 0;
        rst_n  = 1'b0;
        start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;

        #2;
        checkOutput("rst_busy", 32'(busy8), 32'd0);
        checkOutput("rst_done", 32'(done8), 32'd0);
        checkOutput("rst_sum", 32'(sum8), 32'd0);
        checkOutput("rst_carry_out", 32'(co8), 32'd0);
        checkOutput("rst_busy_w1", 32'(busy1), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic add with busy window check.
        applyStimulus(1'b0, 8'h3C, 8'h05, 1'b0, 8'h41, 1'b0);
        checkOutput("busy_after_e0", 32'(busy8), 32'd1);
        repeat (7) @(negedge clk);
        checkOutput("busy_before_e8", 32'(busy8), 32'd1);
        waitDone(1'b0, 12, "op_3c_05");
        checkOutput("busy_after_e8", 32'(busy8), 32'd0);
        @(negedge clk);
        checkOutput("done_one_cycle", 32'(done8), 32'd0);

        applyStimulus(1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        waitDone(1'b0, 12, "op_ff_01");
        applyStimulus(1'b0, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
        waitDone(1'b0, 12, "op_ff_ff_1");

        // Start re-asserted mid-run with new operands must be ignored.
        applyStimulus(1'b0, 8'h10, 8'h20, 1'b0, 8'h30, 1'b0);
        @(negedge clk);
        @(negedge clk);
        start8 = 1'b1; a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b1;
        repeat (3) @(negedge clk);
        start8 = 1'b0; a8 = 8'h77; b8 = 8'h99;
        waitDone(1'b0, 12, "op_ignore_start");
        repeat (3) @(negedge clk);
        checkOutput("no_second_op_busy", 32'(busy8), 32'd0);
        checkOutput("sum_holds", 32'(sum8), 32'h30);

        // Asynchronous reset in the middle of an operation.
        @(negedge clk);
        start8 = 1'b1; a8 = 8'h77; b8 = 8'h11; cin8 = 1'b0;
        @(posedge clk);
        #1 start8 = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("midrst_busy", 32'(busy8), 32'd0);
        checkOutput("midrst_done", 32'(done8), 32'd0);
        checkOutput("midrst_sum", 32'(sum8), 32'd0);
        checkOutput("midrst_carry_out", 32'(co8), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b0, 8'h01, 8'h01, 1'b0, 8'h02, 1'b0);
        waitDone(1'b0, 12, "op_after_reset");

        // Back-to-back with start held high: captures at E0, E9, E18.
        @(negedge clk);
        start8 = 1'b1; a8 = 8'h01; b8 = 8'h02; cin8 = 1'b0;
        q8.push_back('{8'h03, 1'b0, cyc + 9});
        q8.push_back('{8'h07, 1'b0, cyc + 18});
        q8.push_back('{8'h00, 1'b1, cyc + 27});
        @(posedge clk);
        #1 a8 = 8'h03; b8 = 8'h04;
        waitDone(1'b0, 12, "b2b_0");
        @(posedge clk);
        #1 a8 = 8'h80; b8 = 8'h80;
        @(negedge clk);
        checkOutput("b2b_done_width", 32'(done8), 32'd0);
        checkOutput("b2b_sum_hold", 32'(sum8), 32'h03);
        checkOutput("b2b_busy_reaccept", 32'(busy8), 32'd1);
        waitDone(1'b0, 12, "b2b_1");
        @(posedge clk);
        #1 start8 = 1'b0; a8 = 8'h5A; b8 = 8'hA5;
        waitDone(1'b0, 12, "b2b_2");
        repeat (2) @(negedge clk);
        checkOutput("b2b_sum_final_hold", 32'(sum8), 32'h00);

        // WIDTH=1 instance, exhaustive.
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(i);
            exp1 = 2'(v[0]) + 2'(v[1]) + 2'(v[2]);
            applyStimulus(1'b1, {7'b0, v[0]}, {7'b0, v[1]}, v[2], {7'b0, exp1[0]}, exp1[1]);
            waitDone(1'b1, 5, "w1_op");
        end

        repeat (3) @(negedge clk);
        checkOutput("w8_queue_drained", 32'(q8.size()), 32'd0);
        checkOutput("w1_queue_drained", 32'(q1.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
